// File: rtl/ysyx_25040109_mem_mc_if.sv
// Bus bundle for ysyx_25040109_mem_mc: NR read ports (AR/R) and one write port (AW/W/B).
// The memory side uses the slave modport. The core or bench side uses the master modport.
interface ysyx_25040109_mem_mc_if #(parameter int NR = 2);
  logic [NR*32-1:0] r_araddr;
  logic [NR-1:0]    r_arvalid;
  logic [NR-1:0]    r_arready;
  logic [NR*32-1:0] r_rdata;
  logic [NR*2-1:0]  r_rresp;
  logic [NR-1:0]    r_rvalid;
  logic [NR-1:0]    r_rready;
  logic [31:0]      w_awaddr;
  logic             w_awvalid;
  logic             w_awready;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic             w_wvalid;
  logic             w_wready;
  logic [1:0]       w_bresp;
  logic             w_bvalid;
  logic             w_bready;

  modport slave (
    input  r_araddr, r_arvalid, r_rready,
    input  w_awaddr, w_awvalid, w_wdata, w_wstrb, w_wvalid, w_bready,
    output r_arready, r_rdata, r_rresp, r_rvalid,
    output w_awready, w_wready, w_bresp, w_bvalid
  );

  modport master (
    output r_araddr, r_arvalid, r_rready,
    output w_awaddr, w_awvalid, w_wdata, w_wstrb, w_wvalid, w_bready,
    input  r_arready, r_rdata, r_rresp, r_rvalid,
    input  w_awready, w_wready, w_bresp, w_bvalid
  );
endinterface

// File: rtl/ysyx_25040109_mem_mc.sv
// Multi-channel simulation memory: NR independent read ports, one write port, fixed latencies.
// Defining YSYX_MEM_RAND_DELAY_EN adds 0-3 LFSR-driven extra cycles to each latency.
// Backing store is an in-module word array reached through pmem_read and the pmem_write block.

module ysyx_25040109_mem_mc_rport #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arvalid,
  input  logic        i_rready,
  input  logic [1:0]  i_extra,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_resp,
  output logic        o_arready,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rst_e;

  rst_e       r_state, w_nxt;
  logic [7:0] r_cnt;
  logic       w_ar_fire;

  assign w_ar_fire = i_arvalid && (r_state == S_IDLE);

  // The counter is loaded with latency-1 so that RESP is entered exactly RD_LAT edges after the AR fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      o_rdata <= '0;
      o_rresp <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ar_fire) begin
        r_cnt   <= 8'(RD_LAT - 1) + 8'(i_extra);
        o_rdata <= i_data;
        o_rresp <= i_resp;
      end else if (r_state == S_WAIT && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_nxt     = r_state;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) w_nxt = S_WAIT;
      end
      S_WAIT: if (r_cnt == 8'd0) w_nxt = S_RESP;
      S_RESP: begin
        o_rvalid = 1'b1;
        if (i_rready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end
endmodule

module ysyx_25040109_mem_mc #(
  parameter int          NR       = 2,
  parameter int          RD_LAT   = 2,
  parameter int          WR_LAT   = 1,
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000,
  parameter int          MEM_AW   = 12
) (
  input  logic clk,
  input  logic rst,
  ysyx_25040109_mem_mc_if.slave bus
);
  localparam int MEM_WORDS = 1 << MEM_AW;

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_RESP} bst_e;

  // Only MEM_AW word-address bits are backed, so the window aliases onto this array.
  logic [31:0] r_mem [MEM_WORDS];

  function automatic logic in_window(input logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, MEM_BASE};
    hi = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'd4;
    return ({1'b0, a} >= lo) && ({1'b0, a} <= hi);
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    return MEM_AW'((a - MEM_BASE) >> 2);
  endfunction

  function automatic logic [31:0] pmem_read(input logic [31:0] a);
    return r_mem[word_idx(a)];
  endfunction

  logic [NR-1:0][31:0] w_rd_addr, w_rd_word, w_rdata;
  logic [NR-1:0][1:0]  w_rd_resp, w_rresp, w_rd_extra;
  logic [NR-1:0]       w_arready, w_rvalid;
  logic [1:0]          w_wr_extra;

`ifdef YSYX_MEM_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  for (genvar gi = 0; gi < NR; gi++) begin : g_extra
    assign w_rd_extra[gi] = r_lfsr[2*gi +: 2];
  end
  assign w_wr_extra = r_lfsr[1:0];
`else
  assign w_rd_extra = '0;
  assign w_wr_extra = '0;
`endif

  assign w_rd_addr = bus.r_araddr;

  // Data is sampled at the AR-fire edge. Because stores are non-blocking, a read that fires on the
  // same edge as a write commit returns the old data.
  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    assign w_rd_word[gi] = in_window(w_rd_addr[gi]) ? pmem_read(w_rd_addr[gi]) : 32'h0;
    assign w_rd_resp[gi] = in_window(w_rd_addr[gi]) ? 2'b00 : 2'b11;

    ysyx_25040109_mem_mc_rport #(.RD_LAT(RD_LAT)) u_rport (
      .clk       (clk),
      .rst       (rst),
      .i_arvalid (bus.r_arvalid[gi]),
      .i_rready  (bus.r_rready[gi]),
      .i_extra   (w_rd_extra[gi]),
      .i_data    (w_rd_word[gi]),
      .i_resp    (w_rd_resp[gi]),
      .o_arready (w_arready[gi]),
      .o_rvalid  (w_rvalid[gi]),
      .o_rdata   (w_rdata[gi]),
      .o_rresp   (w_rresp[gi])
    );
  end

  assign bus.r_arready = w_arready;
  assign bus.r_rvalid  = w_rvalid;
  assign bus.r_rdata   = w_rdata;
  assign bus.r_rresp   = w_rresp;

  bst_e        r_bstate, w_bnxt;
  logic [7:0]  r_bcnt;
  logic [1:0]  r_bresp;
  logic        r_aw_held, r_w_held;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_b_pending, w_aw_fire, w_w_fire, w_commit, w_c_legal;
  logic [31:0] w_c_addr, w_c_data, w_c_data_sh;
  logic [3:0]  w_c_strb, w_c_strb_sh;

  assign w_b_pending   = (r_bstate != B_IDLE);
  assign bus.w_awready = !r_aw_held && !w_b_pending;
  assign bus.w_wready  = !r_w_held && !w_b_pending;
  assign w_aw_fire     = bus.w_awvalid && bus.w_awready;
  assign w_w_fire      = bus.w_wvalid && bus.w_wready;
  assign w_commit      = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);

  assign w_c_addr    = r_aw_held ? r_awaddr : bus.w_awaddr;
  assign w_c_data    = r_w_held ? r_wdata : bus.w_wdata;
  assign w_c_strb    = r_w_held ? r_wstrb : bus.w_wstrb;
  assign w_c_data_sh = w_c_data << {w_c_addr[1:0], 3'b000};
  assign w_c_strb_sh = w_c_strb << w_c_addr[1:0];
  assign w_c_legal   = in_window(w_c_addr);

  assign bus.w_bvalid = (r_bstate == B_RESP);
  assign bus.w_bresp  = r_bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bstate  <= B_IDLE;
      r_bcnt    <= '0;
      r_bresp   <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_bstate <= w_bnxt;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_c_legal ? 2'b00 : 2'b11;
        r_bcnt    <= 8'(WR_LAT - 1) + 8'(w_wr_extra);
      end else begin
        if (w_aw_fire) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= bus.w_awaddr;
        end
        if (w_w_fire) begin
          r_w_held <= 1'b1;
          r_wdata  <= bus.w_wdata;
          r_wstrb  <= bus.w_wstrb;
        end
        if (r_bstate == B_WAIT && r_bcnt != 8'd0) r_bcnt <= r_bcnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_bnxt = r_bstate;
    case (r_bstate)
      B_IDLE:  if (w_commit) w_bnxt = B_WAIT;
      B_WAIT:  if (r_bcnt == 8'd0) w_bnxt = B_RESP;
      B_RESP:  if (bus.w_bready) w_bnxt = B_IDLE;
      default: w_bnxt = B_IDLE;
    endcase
  end

  // pmem_write: a commit edge that coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_c_legal && w_c_strb_sh != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (w_c_strb_sh[b]) r_mem[word_idx(w_c_addr)][8*b +: 8] <= w_c_data_sh[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ysyx_25040109_mem_mc.sv
// Directed bench for ysyx_25040109_mem_mc (NR=2, RD_LAT=2, WR_LAT=1, 4096-word aliased store).
module tb_ysyx_25040109_mem_mc;
  logic clk, rst;
  int errs = 0, checks = 0;

  ysyx_25040109_mem_mc_if #(.NR(2)) bus ();

  ysyx_25040109_mem_mc #(.NR(2), .RD_LAT(2), .WR_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    bus.r_araddr[32*p +: 32] = a;
    bus.r_arvalid[p] = 1'b1;
    bus.r_rready[p]  = 1'b1;
    tick();
    bus.r_arvalid[p] = 1'b0;
    n = 0;
    while (!bus.r_rvalid[p] && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin errs++; $display("FAIL rd_timeout port=%0d addr=%h", p, a); end
    d = bus.r_rdata[32*p +: 32];
    r = bus.r_rresp[2*p +: 2];
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    int n;
    bus.w_awaddr = a; bus.w_awvalid = 1'b1;
    bus.w_wdata = d; bus.w_wstrb = s; bus.w_wvalid = 1'b1;
    bus.w_bready = 1'b1;
    tick();
    bus.w_awvalid = 1'b0; bus.w_wvalid = 1'b0;
    n = 0;
    while (!bus.w_bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin errs++; $display("FAIL wr_timeout addr=%h", a); end
    r = bus.w_bresp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (bus.r_arready !== 2'b11 || bus.r_rvalid !== 2'b00) begin
      errs++; $display("FAIL reset_rd got ardy=%b rvld=%b want 11/00", bus.r_arready, bus.r_rvalid);
    end
    checks++;
    if (bus.r_rdata !== 64'h0 || bus.r_rresp !== 4'h0) begin
      errs++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.r_rdata, bus.r_rresp);
    end
    checks++;
    if (bus.w_awready !== 1'b1 || bus.w_wready !== 1'b1 || bus.w_bvalid !== 1'b0 || bus.w_bresp !== 2'b00) begin
      errs++; $display("FAIL reset_wr got aw=%b w=%b bv=%b br=%b want 1/1/0/00",
                       bus.w_awready, bus.w_wready, bus.w_bvalid, bus.w_bresp);
    end
    rst = 1'b0;
    tick();
    // Reset asserted while port 0 sits in WAIT
    bus.r_araddr[31:0] = 32'h8000_0000; bus.r_arvalid[0] = 1'b1; bus.r_rready[0] = 1'b1;
    tick();
    bus.r_arvalid[0] = 1'b0;
    checks++;
    if (bus.r_arready[0] !== 1'b0) begin errs++; $display("FAIL wait_ardy got %b want 0", bus.r_arready[0]); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.r_arready[0] !== 1'b1 || bus.r_rvalid[0] !== 1'b0) begin
      errs++; $display("FAIL midrst got ardy=%b rvld=%b want 1/0", bus.r_arready[0], bus.r_rvalid[0]);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.r_rvalid[0] !== 1'b0) begin errs++; $display("FAIL midrst_rvalid cyc=%0d got 1 want 0", i); end
    end
  endtask

  task automatic test_preload();
    logic [1:0] r;
    wr(32'h8000_0000, 32'h1122_3344, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errs++; $display("FAIL preload0_bresp got %b want 00", r); end
    wr(32'h8000_0004, 32'h5566_7788, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errs++; $display("FAIL preload1_bresp got %b want 00", r); end
  endtask

  task automatic test_read_latency();
    bus.r_araddr[31:0] = 32'h8000_0000; bus.r_arvalid[0] = 1'b1; bus.r_rready[0] = 1'b1;
    tick();
    bus.r_arvalid[0] = 1'b0;
    checks++;
    if (bus.r_rvalid[0] !== 1'b0 || bus.r_arready[0] !== 1'b0) begin
      errs++; $display("FAIL lat_T got rvld=%b ardy=%b want 0/0", bus.r_rvalid[0], bus.r_arready[0]);
    end
    tick();
    checks++;
    if (bus.r_rvalid[0] !== 1'b0) begin errs++; $display("FAIL lat_T1 got rvalid=1 want 0"); end
    tick();
    checks++;
    if (bus.r_rvalid[0] !== 1'b1 || bus.r_rdata[31:0] !== 32'h1122_3344 || bus.r_rresp[1:0] !== 2'b00) begin
      errs++; $display("FAIL lat_T2 got v=%b d=%h r=%b want 1/11223344/00",
                       bus.r_rvalid[0], bus.r_rdata[31:0], bus.r_rresp[1:0]);
    end
    tick();
    checks++;
    if (bus.r_rvalid[0] !== 1'b0 || bus.r_arready[0] !== 1'b1) begin
      errs++; $display("FAIL lat_T3 got rvld=%b ardy=%b want 0/1", bus.r_rvalid[0], bus.r_arready[0]);
    end
  endtask

  task automatic test_dual_port();
    bus.r_araddr = {32'h8000_0004, 32'h8000_0000};
    bus.r_arvalid = 2'b11; bus.r_rready = 2'b11;
    tick();
    bus.r_arvalid = 2'b00;
    tick(); tick();
    checks++;
    if (bus.r_rvalid !== 2'b11 || bus.r_rdata !== {32'h5566_7788, 32'h1122_3344}) begin
      errs++; $display("FAIL dual got v=%b d=%h want 11/5566778811223344", bus.r_rvalid, bus.r_rdata);
    end
    tick();
  endtask

  task automatic test_partial_write();
    logic [31:0] d; logic [1:0] r;
    bus.w_awaddr = 32'h8000_0002; bus.w_awvalid = 1'b1; bus.w_bready = 1'b0;
    tick();
    bus.w_awvalid = 1'b0;
    checks++;
    if (bus.w_awready !== 1'b0 || bus.w_wready !== 1'b1) begin
      errs++; $display("FAIL aw_held got aw=%b w=%b want 0/1", bus.w_awready, bus.w_wready);
    end
    bus.w_wdata = 32'h0000_ABCD; bus.w_wstrb = 4'b0011; bus.w_wvalid = 1'b1;
    tick();
    bus.w_wvalid = 1'b0;
    checks++;
    if (bus.w_bvalid !== 1'b0 || bus.w_wready !== 1'b0 || bus.w_awready !== 1'b0) begin
      errs++; $display("FAIL commit got bv=%b w=%b aw=%b want 0/0/0", bus.w_bvalid, bus.w_wready, bus.w_awready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.w_bvalid !== 1'b1 || bus.w_awready !== 1'b0 || bus.w_bresp !== 2'b00) begin
        errs++; $display("FAIL bhold cyc=%0d got bv=%b aw=%b br=%b want 1/0/00",
                         i, bus.w_bvalid, bus.w_awready, bus.w_bresp);
      end
    end
    bus.w_bready = 1'b1;
    tick();
    checks++;
    if (bus.w_bvalid !== 1'b0 || bus.w_awready !== 1'b1) begin
      errs++; $display("FAIL bfire got bv=%b aw=%b want 0/1", bus.w_bvalid, bus.w_awready);
    end
    rd(0, 32'h8000_0000, d, r);
    checks++;
    if (d !== 32'hABCD_3344) begin errs++; $display("FAIL half_write got %h want abcd3344", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int n;
    bus.w_wdata = 32'h0000_00EE; bus.w_wstrb = 4'b0001; bus.w_wvalid = 1'b1; bus.w_bready = 1'b1;
    tick();
    bus.w_wvalid = 1'b0;
    checks++;
    if (bus.w_wready !== 1'b0 || bus.w_awready !== 1'b1) begin
      errs++; $display("FAIL w_held got w=%b aw=%b want 0/1", bus.w_wready, bus.w_awready);
    end
    bus.w_awaddr = 32'h8000_0007; bus.w_awvalid = 1'b1;
    tick();
    bus.w_awvalid = 1'b0;
    n = 0;
    while (!bus.w_bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin errs++; $display("FAIL wfirst_timeout"); end
    tick();
    rd(1, 32'h8000_0004, d, r);
    checks++;
    if (d !== 32'hEE66_7788) begin errs++; $display("FAIL byte3_write got %h want ee667788", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic [1:0] r;
    rd(1, 32'h7FFF_FFFC, d, r);
    checks++;
    if (r !== 2'b11 || d !== 32'h0) begin errs++; $display("FAIL rd_below got %b/%h want 11/0", r, d); end
    rd(0, 32'h87FF_FFFC, d, r);
    checks++;
    if (r !== 2'b00) begin errs++; $display("FAIL rd_top got %b want 00", r); end
    rd(0, 32'h87FF_FFFD, d, r);
    checks++;
    if (r !== 2'b11 || d !== 32'h0) begin errs++; $display("FAIL rd_past got %b/%h want 11/0", r, d); end
    wr(32'h8800_0000, 32'hDEAD_BEEF, 4'hF, r);
    checks++;
    if (r !== 2'b11) begin errs++; $display("FAIL wr_illegal got %b want 11", r); end
    rd(0, 32'h8000_0000, d, r);
    checks++;
    if (d !== 32'hABCD_3344 || r !== 2'b00) begin
      errs++; $display("FAIL mem_unchanged got %h/%b want abcd3344/00", d, r);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] d; logic [1:0] r;
    bus.w_awaddr = 32'h8000_0004; bus.w_awvalid = 1'b1;
    bus.w_wdata = 32'hCAFE_F00D; bus.w_wstrb = 4'hF; bus.w_wvalid = 1'b1; bus.w_bready = 1'b1;
    bus.r_araddr[63:32] = 32'h8000_0004; bus.r_arvalid[1] = 1'b1; bus.r_rready[1] = 1'b1;
    tick();
    bus.w_awvalid = 1'b0; bus.w_wvalid = 1'b0; bus.r_arvalid[1] = 1'b0;
    tick();
    checks++;
    if (bus.w_bvalid !== 1'b1 || bus.w_bresp !== 2'b00) begin
      errs++; $display("FAIL same_b got bv=%b br=%b want 1/00", bus.w_bvalid, bus.w_bresp);
    end
    tick();
    checks++;
    if (bus.r_rvalid[1] !== 1'b1 || bus.r_rdata[63:32] !== 32'hEE66_7788) begin
      errs++; $display("FAIL same_old got v=%b d=%h want 1/ee667788", bus.r_rvalid[1], bus.r_rdata[63:32]);
    end
    tick();
    rd(1, 32'h8000_0004, d, r);
    checks++;
    if (d !== 32'hCAFE_F00D) begin errs++; $display("FAIL same_new got %h want cafef00d", d); end
  endtask

  initial begin
    rst = 1'b1;
    bus.r_araddr = '0; bus.r_arvalid = '0; bus.r_rready = '0;
    bus.w_awaddr = '0; bus.w_awvalid = 1'b0; bus.w_wdata = '0; bus.w_wstrb = '0;
    bus.w_wvalid = 1'b0; bus.w_bready = 1'b0;
    test_reset();
    test_preload();
    test_read_latency();
    test_dual_port();
    test_partial_write();
    test_w_before_aw();
    test_illegal();
    test_same_edge();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
